uart_cmd_wrapper: RTL and testbench

Serial front end of KnightsTour: it sits between the RX/TX pins and the command processor. It deserializes 8N1 UART bytes arriving from the remote controller, packs two consecutive bytes (high byte first) into a 16-bit command, and presents it with a ready/clear handshake. It also serializes the 8-bit response (e.g. 0xA5 for a normal ack, 0x5A for calibration done) back onto TX.

---
 rtl/uart_cmd_wrapper.sv | 203 ++++++++++++++++++++
 tb/tb_uart_cmd_wrapper.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_wrapper.sv
// UART 8N1 command front end: pairs of RX bytes become a 16-bit cmd with ready/clear handshake; TX serializes resp.
// Optional macro CMD_TIMEOUT_EN drops a stale high byte if the low byte does not start within TIMEOUT clocks.
module uart_cmd_wrapper #(
  parameter int BAUD_DIV = 2604,
  parameter int TIMEOUT  = 1_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RX,
  output logic        TX,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic [7:0]  resp,
  input  logic        trmt,
  output logic        tx_done,
  output logic        frm_err
);

  localparam int CW = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] BAUD_FULL = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] BAUD_HALF = CW'(BAUD_DIV / 2 - 1);

  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;
  localparam logic [0:0] WAIT_HI  = 1'b0;
  localparam logic [0:0] WAIT_LO  = 1'b1;
  localparam logic [0:0] TX_IDLE  = 1'b0;
  localparam logic [0:0] TX_SHIFT = 1'b1;

  if (BAUD_DIV < 16 || TIMEOUT < 1) begin : g_bad_param
    $error("uart_cmd_wrapper: BAUD_DIV must be >= 16 and TIMEOUT >= 1");
  end

  logic          rx_s1_q, rx_s1_d, rx_s2_q, rx_s2_d, rx_s3_q, rx_s3_d;
  logic [1:0]    rx_st_q, rx_st_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]    rx_bit_q, rx_bit_d;
  logic [7:0]    rx_sh_q, rx_sh_d;
  logic          frm_err_q, frm_err_d;
  logic [0:0]    asm_st_q, asm_st_d;
  logic [7:0]    shadow_hi_q, shadow_hi_d;
  logic [15:0]   cmd_q, cmd_d;
  logic          cmd_rdy_q, cmd_rdy_d;
  logic [0:0]    tx_st_q, tx_st_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [3:0]    tx_bit_q, tx_bit_d;
  logic [9:0]    tx_sh_q, tx_sh_d;
  logic          tx_done_q, tx_done_d;
  logic          byte_vld, cmd_done;
`ifdef CMD_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] to_cnt_q, to_cnt_d;
`endif

  always_comb begin
    rx_s1_d     = RX;
    rx_s2_d     = rx_s1_q;
    rx_s3_d     = rx_s2_q;
    rx_st_d     = rx_st_q;
    rx_cnt_d    = rx_cnt_q;
    rx_bit_d    = rx_bit_q;
    rx_sh_d     = rx_sh_q;
    frm_err_d   = 1'b0;
    byte_vld    = 1'b0;
    cmd_done    = 1'b0;
    asm_st_d    = asm_st_q;
    shadow_hi_d = shadow_hi_q;
    cmd_d       = cmd_q;
    cmd_rdy_d   = cmd_rdy_q;
    tx_st_d     = tx_st_q;
    tx_cnt_d    = tx_cnt_q;
    tx_bit_d    = tx_bit_q;
    tx_sh_d     = tx_sh_q;
    tx_done_d   = tx_done_q;
`ifdef CMD_TIMEOUT_EN
    to_cnt_d    = to_cnt_q;
`endif

    // rx_s2/rx_s3 form the synchronized edge detector; samples use rx_s2
    case (rx_st_q)
      RX_IDLE: if (!rx_s2_q && rx_s3_q) begin
        rx_st_d  = RX_START;
        rx_cnt_d = BAUD_HALF;
      end
      RX_START: if (rx_cnt_q == '0) begin
        if (rx_s2_q) rx_st_d = RX_IDLE;
        else begin
          rx_st_d  = RX_DATA;
          rx_cnt_d = BAUD_FULL;
          rx_bit_d = 3'd0;
        end
      end else rx_cnt_d = rx_cnt_q - 1'b1;
      RX_DATA: if (rx_cnt_q == '0) begin
        rx_sh_d  = {rx_s2_q, rx_sh_q[7:1]};
        rx_cnt_d = BAUD_FULL;
        if (rx_bit_q == 3'd7) rx_st_d = RX_STOP;
        else rx_bit_d = rx_bit_q + 1'b1;
      end else rx_cnt_d = rx_cnt_q - 1'b1;
      default: if (rx_cnt_q == '0) begin
        rx_st_d = RX_IDLE;
        if (rx_s2_q) byte_vld = 1'b1;
        else frm_err_d = 1'b1;
      end else rx_cnt_d = rx_cnt_q - 1'b1;
    endcase

    if (frm_err_d) asm_st_d = WAIT_HI;
    else if (byte_vld) begin
      if (asm_st_q == WAIT_HI) begin
        shadow_hi_d = rx_sh_q;
        asm_st_d    = WAIT_LO;
      end else begin
        cmd_d    = {shadow_hi_q, rx_sh_q};
        cmd_done = 1'b1;
        asm_st_d = WAIT_HI;
      end
    end
`ifdef CMD_TIMEOUT_EN
    // Only idle line time counts; a low byte already in flight is allowed to finish
    else if (asm_st_q == WAIT_LO && rx_st_q == RX_IDLE) begin
      if (to_cnt_q == TW'(TIMEOUT - 1)) asm_st_d = WAIT_HI;
      else to_cnt_d = to_cnt_q + 1'b1;
    end
    if (asm_st_d != WAIT_LO) to_cnt_d = '0;
`endif

    if (cmd_done) cmd_rdy_d = 1'b1;
    else if (clr_cmd_rdy) cmd_rdy_d = 1'b0;

    case (tx_st_q)
      TX_IDLE: if (trmt) begin
        tx_sh_d   = {1'b1, resp, 1'b0};
        tx_done_d = 1'b0;
        tx_cnt_d  = BAUD_FULL;
        tx_bit_d  = 4'd0;
        tx_st_d   = TX_SHIFT;
      end
      default: if (tx_cnt_q == '0) begin
        tx_sh_d  = {1'b1, tx_sh_q[9:1]};
        tx_cnt_d = BAUD_FULL;
        if (tx_bit_q == 4'd9) begin
          tx_st_d   = TX_IDLE;
          tx_done_d = 1'b1;
        end else tx_bit_d = tx_bit_q + 1'b1;
      end else tx_cnt_d = tx_cnt_q - 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1_q     <= 1'b1;
      rx_s2_q     <= 1'b1;
      rx_s3_q     <= 1'b1;
      rx_st_q     <= RX_IDLE;
      rx_cnt_q    <= '0;
      rx_bit_q    <= 3'd0;
      rx_sh_q     <= 8'h00;
      frm_err_q   <= 1'b0;
      asm_st_q    <= WAIT_HI;
      shadow_hi_q <= 8'h00;
      cmd_q       <= 16'h0000;
      cmd_rdy_q   <= 1'b0;
      tx_st_q     <= TX_IDLE;
      tx_cnt_q    <= '0;
      tx_bit_q    <= 4'd0;
      tx_sh_q     <= '1;
      tx_done_q   <= 1'b0;
`ifdef CMD_TIMEOUT_EN
      to_cnt_q    <= '0;
`endif
    end else begin
      rx_s1_q     <= rx_s1_d;
      rx_s2_q     <= rx_s2_d;
      rx_s3_q     <= rx_s3_d;
      rx_st_q     <= rx_st_d;
      rx_cnt_q    <= rx_cnt_d;
      rx_bit_q    <= rx_bit_d;
      rx_sh_q     <= rx_sh_d;
      frm_err_q   <= frm_err_d;
      asm_st_q    <= asm_st_d;
      shadow_hi_q <= shadow_hi_d;
      cmd_q       <= cmd_d;
      cmd_rdy_q   <= cmd_rdy_d;
      tx_st_q     <= tx_st_d;
      tx_cnt_q    <= tx_cnt_d;
      tx_bit_q    <= tx_bit_d;
      tx_sh_q     <= tx_sh_d;
      tx_done_q   <= tx_done_d;
`ifdef CMD_TIMEOUT_EN
      to_cnt_q    <= to_cnt_d;
`endif
    end
  end

  assign TX      = tx_sh_q[0];
  assign cmd     = cmd_q;
  assign cmd_rdy = cmd_rdy_q;
  assign tx_done = tx_done_q;
  assign frm_err = frm_err_q;

endmodule

// File: tb/tb_uart_cmd_wrapper.sv
// Self-checking bench for uart_cmd_wrapper: vector table, hand-written corner sequences and random bytes vs a pairing model.
module tb_uart_cmd_wrapper;
  localparam int B  = 16;
  localparam int TO = 5000;

  logic        clk = 1'b0;
  logic        rst_n, RX, TX, cmd_rdy, clr_cmd_rdy, trmt, tx_done, frm_err;
  logic [15:0] cmd;
  logic [7:0]  resp;

  int checks = 0;
  int errors = 0;
  int frm_cnt = 0;

  // Reference model: bytes pair up high-then-low; a framing error forgets a pending high byte
  bit          pend;
  logic [7:0]  pend_b;
  logic [15:0] exp_cmd;
  bit          exp_rdy;

  typedef struct {
    logic [7:0]  hi;
    logic [7:0]  lo;
    logic [15:0] exp;
  } vec_t;
  vec_t vecs[4];

  uart_cmd_wrapper #(.BAUD_DIV(B), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .RX(RX), .TX(TX), .cmd(cmd), .cmd_rdy(cmd_rdy),
    .clr_cmd_rdy(clr_cmd_rdy), .resp(resp), .trmt(trmt), .tx_done(tx_done), .frm_err(frm_err)
  );

  always #5 clk = ~clk;
  always @(negedge clk) if (frm_err === 1'b1) frm_cnt++;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    pend = 0; pend_b = 8'h00; exp_cmd = 16'h0000; exp_rdy = 0;
  endtask

  task automatic model_byte(input logic [7:0] b);
    if (pend) begin
      exp_cmd = {pend_b, b};
      exp_rdy = 1;
      pend = 0;
    end else begin
      pend = 1;
      pend_b = b;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      RX = fr[i];
      repeat (B) @(negedge clk);
    end
    RX = 1'b1;
  endtask

  task automatic send_m(input logic [7:0] b);
    send_byte(b, 1'b1);
    model_byte(b);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
`ifdef CMD_TIMEOUT_EN
    if (n >= TO) pend = 0;
`endif
  endtask

  task automatic clr_pulse();
    clr_cmd_rdy = 1'b1;
    @(negedge clk);
    clr_cmd_rdy = 1'b0;
    exp_rdy = 0;
    chk("clr_rdy", {15'd0, cmd_rdy}, 16'd0);
  endtask

  task automatic tx_check(input logic [7:0] r, input bit inject);
    logic [9:0] fr;
    int bad;
    fr = {1'b1, r, 1'b0};
    bad = 0;
    resp = r; trmt = 1'b1;
    @(negedge clk);
    trmt = 1'b0;
    for (int i = 0; i < 10 * B; i++) begin
      if (TX !== fr[i / B]) bad++;
      if (tx_done !== 1'b0) bad++;
      if (inject) begin
        trmt = (i == 3 * B);
        if (i == 3 * B) resp = ~r;
      end
      @(negedge clk);
    end
    chk("tx_frame_bad_cycles", 16'(bad), 16'd0);
    chk("tx_done_set", {15'd0, tx_done}, 16'd1);
    chk("tx_idle_high", {15'd0, TX}, 16'd1);
  endtask

  initial begin
    vecs[0] = '{8'h00, 8'h00, 16'h0000};
    vecs[1] = '{8'h4B, 8'h1E, 16'h4B1E};
    vecs[2] = '{8'hC3, 8'h3C, 16'hC33C};
    vecs[3] = '{8'hFF, 8'h80, 16'hFF80};

    rst_n = 1'b0; RX = 1'b1; trmt = 1'b0; clr_cmd_rdy = 1'b0; resp = 8'h00;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_tx", {15'd0, TX}, 16'd1);
    chk("rst_cmd", cmd, 16'h0000);
    chk("rst_rdy", {15'd0, cmd_rdy}, 16'd0);
    chk("rst_tx_done", {15'd0, tx_done}, 16'd0);
    chk("rst_frm_err", {15'd0, frm_err}, 16'd0);
    rst_n = 1'b1;
    idle(2);

    foreach (vecs[k]) begin
      send_m(vecs[k].hi);
      send_m(vecs[k].lo);
      idle(4);
      chk("vec_cmd", cmd, vecs[k].exp);
      chk("vec_rdy", {15'd0, cmd_rdy}, 16'd1);
      clr_pulse();
      chk("vec_cmd_hold", cmd, vecs[k].exp);
    end

    tx_check(8'h5A, 1'b1);
    idle(20);
    chk("tx_done_sticky", {15'd0, tx_done}, 16'd1);
    tx_check(8'hA5, 1'b0);

    // Stop bit held low on a high byte
    frm_cnt = 0;
    send_byte(8'h55, 1'b0);
    pend = 0;
    idle(4);
    chk("frm_err_pulses", 16'(frm_cnt), 16'd1);
    chk("frm_rdy_low", {15'd0, cmd_rdy}, 16'd0);
    send_m(8'h12);
    send_m(8'h34);
    idle(4);
    chk("after_frm_cmd", cmd, 16'h1234);
    chk("after_frm_rdy", {15'd0, cmd_rdy}, 16'd1);

    // clr_cmd_rdy lands on the completion edge of a new command
    send_m(8'hAB);
    fork
      send_m(8'hCD);
      begin
        repeat (154) @(negedge clk);
        chk("pre_done_cmd", cmd, 16'h1234);
        clr_cmd_rdy = 1'b1;
        @(negedge clk);
        clr_cmd_rdy = 1'b0;
        chk("set_wins_cmd", cmd, 16'hABCD);
      end
    join
    idle(2);
    chk("set_wins_rdy", {15'd0, cmd_rdy}, 16'd1);
    clr_pulse();

    for (int n = 0; n < 8; n++) begin
      logic [7:0] b;
      b = 8'($urandom);
      if (n == 3) fork
        send_m(b);
        tx_check(8'($urandom), 1'b0);
      join
      else send_m(b);
      idle(2 + int'($urandom_range(0, 30)));
      chk("rand_cmd", cmd, exp_cmd);
      chk("rand_rdy", {15'd0, cmd_rdy}, {15'd0, exp_rdy});
      if ($urandom_range(0, 1) == 1) clr_pulse();
    end

    if (pend) send_m(8'h00);
    send_m(8'h77);
    idle(6000);
    send_m(8'h88);
    send_m(8'h99);
    idle(4);
`ifdef CMD_TIMEOUT_EN
    chk("timeout_cmd", cmd, 16'h8899);
`else
    chk("timeout_cmd", cmd, 16'h7788);
`endif
    chk("timeout_model", cmd, exp_cmd);

    // Reset in the middle of a low byte while TX is sending zeros
    if (!pend) send_m(8'h5C);
    resp = 8'h00; trmt = 1'b1;
    @(negedge clk);
    trmt = 1'b0;
    RX = 1'b0;
    repeat (B) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      RX = i[0];
      repeat (B) @(negedge clk);
    end
    chk("mid_tx_low", {15'd0, TX}, 16'd0);
    rst_n = 1'b0;
    #1;
    chk("arst_tx", {15'd0, TX}, 16'd1);
    chk("arst_cmd", cmd, 16'h0000);
    chk("arst_rdy", {15'd0, cmd_rdy}, 16'd0);
    chk("arst_tx_done", {15'd0, tx_done}, 16'd0);
    chk("arst_frm_err", {15'd0, frm_err}, 16'd0);
    RX = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle(4);
    send_m(8'h00);
    send_m(8'h01);
    idle(4);
    chk("post_rst_cmd", cmd, 16'h0001);
    chk("post_rst_rdy", {15'd0, cmd_rdy}, 16'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
